// File: rtl/dice_table_ctrl_if.sv
// dice_table_ctrl_if: handshake between the table controller (master) and the dice game core (slave)
interface dice_table_ctrl_if;
    logic       core_rst;
    logic       core_rb;
    logic [3:0] core_sum;
    logic       core_win;
    logic       core_lose;
    modport master (output core_rst, core_rb, core_sum, input core_win, core_lose);
    modport slave (input core_rst, core_rb, core_sum, output core_win, core_lose);
endinterface

// File: rtl/dice_table_ctrl.sv
// dice_table_ctrl: round-robin dice table sharing one game core; define DICE_TIMEOUT_EN for the ARM forfeit timeout
module dice_table_ctrl #(
    parameter int NUM_PLAYERS     = 4,
    parameter int SCORE_W         = 8,
    parameter int ROLL_MIN_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PLAYERS-1:0]         btn,
    dice_table_ctrl_if.master              core,
    output logic [2:0]                     die1,
    output logic [2:0]                     die2,
    output logic                           busy,
    output logic [1:0]                     owner,
    output logic                           result_valid,
    output logic                           result_win,
    output logic [1:0]                     result_player,
    output logic                           result_forfeit,
    output logic [NUM_PLAYERS*SCORE_W-1:0] wins
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_ARM     = 3'd2;
    localparam logic [2:0] S_ROLL    = 3'd3;
    localparam logic [2:0] S_PRESENT = 3'd4;
    localparam logic [2:0] S_SETTLE  = 3'd5;
    localparam logic [2:0] S_CHECK   = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;
    localparam int CW = $clog2(ROLL_MIN_CYCLES + 1);
    localparam logic [CW-1:0] MIN_M1 = CW'(ROLL_MIN_CYCLES - 1);

    logic [2:0]                     state_q, state_d, die1_q, die1_d, die2_q, die2_d;
    logic [1:0]                     owner_q, owner_d, last_q, last_d, grant;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic                           win_q, win_d, own_btn, found;
    logic [NUM_PLAYERS*SCORE_W-1:0] wins_q, wins_d;
    int                             j;
`ifdef DICE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_M1 = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          forfeit_q, forfeit_d;
`endif

    if (NUM_PLAYERS < 2 || NUM_PLAYERS > 4 || ROLL_MIN_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("dice_table_ctrl: illegal parameter value");
    end

    assign own_btn = |(btn & (NUM_PLAYERS'(1) << owner_q));

    // search upward from last_owner+1 so the previous owner ranks last
    always_comb begin
        grant = last_q;
        found = 1'b0;
        j     = 0;
        for (int i = 1; i <= NUM_PLAYERS; i++) begin
            j = (int'(last_q) + i) % NUM_PLAYERS;
            if (!found && |(btn & (NUM_PLAYERS'(1) << j))) begin
                grant = 2'(j);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        die1_d  = die1_q;
        die2_d  = die2_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = '0;
        win_d   = win_q;
        wins_d  = wins_q;
`ifdef DICE_TIMEOUT_EN
        tmo_d     = '0;
        forfeit_d = forfeit_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|btn) begin
                    owner_d = grant;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: state_d = S_ARM;
            S_ARM: begin
                if (own_btn) state_d = S_ROLL;
`ifdef DICE_TIMEOUT_EN
                else if (tmo_q == TMO_M1) begin
                    state_d   = S_DONE;
                    win_d     = 1'b0;
                    forfeit_d = 1'b1;
                end
                tmo_d = tmo_q + 1'b1;
`endif
            end
            S_ROLL: begin
                die1_d = die1_q == 3'd6 ? 3'd1 : die1_q + 3'd1;
                die2_d = die1_q != 3'd6 ? die2_q : die2_q == 3'd6 ? 3'd1 : die2_q + 3'd1;
                cnt_d  = cnt_q == MIN_M1 ? cnt_q : cnt_q + 1'b1;
                if (!own_btn && cnt_q == MIN_M1) state_d = S_PRESENT;
            end
            S_PRESENT: state_d = S_SETTLE;
            S_SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q != '0) state_d = S_CHECK;
            end
            S_CHECK: begin
                win_d   = core.core_win;
                state_d = core.core_win || core.core_lose ? S_DONE : S_ARM;
`ifdef DICE_TIMEOUT_EN
                forfeit_d = 1'b0;
`endif
            end
            S_DONE: begin
                last_d  = owner_q;
                state_d = S_IDLE;
                for (int i = 0; i < NUM_PLAYERS; i++)
                    if (win_q && owner_q == 2'(i) && !(&wins_q[i*SCORE_W +: SCORE_W]))
                        wins_d[i*SCORE_W +: SCORE_W] = wins_q[i*SCORE_W +: SCORE_W] + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            die1_q  <= 3'd1;
            die2_q  <= 3'd1;
            owner_q <= '0;
            last_q  <= 2'(NUM_PLAYERS - 1);
            cnt_q   <= '0;
            win_q   <= 1'b0;
            wins_q  <= '0;
`ifdef DICE_TIMEOUT_EN
            tmo_q     <= '0;
            forfeit_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            die1_q  <= die1_d;
            die2_q  <= die2_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            wins_q  <= wins_d;
`ifdef DICE_TIMEOUT_EN
            tmo_q     <= tmo_d;
            forfeit_q <= forfeit_d;
`endif
        end
    end

    assign core.core_rst = state_q == S_CLEAR;
    assign core.core_rb  = state_q == S_PRESENT;
    assign core.core_sum = {1'b0, die1_q} + {1'b0, die2_q};
    assign die1          = die1_q;
    assign die2          = die2_q;
    assign busy          = state_q != S_IDLE;
    assign owner         = owner_q;
    assign result_valid  = state_q == S_DONE;
    assign result_win    = result_valid & win_q;
    assign result_player = result_valid ? owner_q : 2'd0;
    assign wins          = wins_q;
`ifdef DICE_TIMEOUT_EN
    assign result_forfeit = result_valid & forfeit_q;
`else
    assign result_forfeit = 1'b0;
`endif
endmodule

// File: tb/tb_dice_table_ctrl.sv
// tb_dice_table_ctrl: directed vector table of rolls plus reset, arbitration and timeout sequences
module tb_dice_table_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn = 4'b0000;
    logic [2:0] die1, die2;
    logic       busy, result_valid, result_win, result_forfeit;
    logic [1:0] owner, result_player;
    logic [7:0] wins;
    int         errors = 0;
    int         checks = 0;

    dice_table_ctrl_if cif ();

    dice_table_ctrl #(
        .NUM_PLAYERS(4), .SCORE_W(2), .ROLL_MIN_CYCLES(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .btn(btn), .core(cif.master),
        .die1(die1), .die2(die2), .busy(busy), .owner(owner),
        .result_valid(result_valid), .result_win(result_win),
        .result_player(result_player), .result_forfeit(result_forfeit), .wins(wins)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       start;
        logic [3:0] mask;
        int         p;
        int         hold;
        logic       win;
        logic       lose;
        int         occ;
        logic [2:0] d1;
        logic [2:0] d2;
        logic [3:0] sum;
        logic       done;
        logic       rwin;
        logic [7:0] wins;
    } vec_t;

    vec_t tv[10];
    int   occ;
    int   cyc;
    logic seen_rv, seen_rb;

    initial begin
        tv[0] = '{1'b1, 4'b0001, 0, 19, 1'b1, 1'b0, 20, 3'd3, 3'd4, 4'd7,  1'b1, 1'b1, 8'h01};
        tv[1] = '{1'b1, 4'b0001, 0, 17, 1'b0, 1'b0, 18, 3'd3, 3'd1, 4'd4,  1'b0, 1'b0, 8'h01};
        tv[2] = '{1'b0, 4'b0000, 0, 7,  1'b0, 1'b1, 8,  3'd5, 3'd2, 4'd7,  1'b1, 1'b0, 8'h01};
        tv[3] = '{1'b1, 4'b0110, 1, 0,  1'b1, 1'b0, 4,  3'd3, 3'd3, 4'd6,  1'b1, 1'b1, 8'h05};
        tv[4] = '{1'b1, 4'b0110, 2, 3,  1'b1, 1'b1, 4,  3'd1, 3'd4, 4'd5,  1'b1, 1'b1, 8'h15};
        tv[5] = '{1'b1, 4'b1111, 3, 4,  1'b0, 1'b1, 5,  3'd6, 3'd4, 4'd10, 1'b1, 1'b0, 8'h15};
        tv[6] = '{1'b1, 4'b1001, 0, 11, 1'b0, 1'b0, 12, 3'd6, 3'd6, 4'd12, 1'b0, 1'b0, 8'h15};
        tv[7] = '{1'b0, 4'b0000, 0, 0,  1'b1, 1'b0, 4,  3'd4, 3'd1, 4'd5,  1'b1, 1'b1, 8'h16};
        tv[8] = '{1'b1, 4'b0001, 0, 3,  1'b1, 1'b0, 4,  3'd2, 3'd2, 4'd4,  1'b1, 1'b1, 8'h17};
        tv[9] = '{1'b1, 4'b0001, 0, 3,  1'b1, 1'b0, 4,  3'd6, 3'd2, 4'd8,  1'b1, 1'b1, 8'h17};
        cif.core_win  = 1'b0;
        cif.core_lose = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_die1", 32'(die1), 1);
        chk("rst_die2", 32'(die2), 1);
        chk("rst_sum", 32'(cif.core_sum), 2);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_core_rst", 32'(cif.core_rst), 0);
        chk("rst_core_rb", 32'(cif.core_rb), 0);
        chk("rst_result_valid", 32'(result_valid), 0);
        chk("rst_wins", 32'(wins), 0);

        for (int v = 0; v < 10; v++) begin
            if (tv[v].start) begin
                btn = tv[v].mask;
                @(posedge clk);
                @(negedge clk);
                chk("grant_owner", 32'(owner), 32'(tv[v].p));
                chk("grant_busy", 32'(busy), 1);
                chk("clear_core_rst", 32'(cif.core_rst), 1);
                @(posedge clk);
                @(negedge clk);
                chk("arm_core_rst", 32'(cif.core_rst), 0);
            end
            cif.core_win  = tv[v].win;
            cif.core_lose = tv[v].lose;
            btn[tv[v].p] = 1'b1;
            @(posedge clk);
            repeat (tv[v].hold) @(posedge clk);
            @(negedge clk);
            btn[tv[v].p] = 1'b0;
            occ = tv[v].hold;
            for (int i = 0; i < 64; i++) begin
                @(posedge clk);
                occ++;
                @(negedge clk);
                if (cif.core_rb) break;
            end
            chk("roll_occupancy", 32'(occ), 32'(tv[v].occ));
            chk("present_core_rb", 32'(cif.core_rb), 1);
            chk("present_die1", 32'(die1), 32'(tv[v].d1));
            chk("present_die2", 32'(die2), 32'(tv[v].d2));
            chk("present_sum", 32'(cif.core_sum), 32'(tv[v].sum));
            @(posedge clk);
            @(negedge clk);
            chk("settle_core_rb", 32'(cif.core_rb), 0);
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            chk("check_sum_stable", 32'(cif.core_sum), 32'(tv[v].sum));
            chk("check_no_result", 32'(result_valid), 0);
            @(posedge clk);
            @(negedge clk);
            chk("result_valid", 32'(result_valid), 32'(tv[v].done));
            if (tv[v].done) begin
                chk("result_win", 32'(result_win), 32'(tv[v].rwin));
                chk("result_player", 32'(result_player), 32'(tv[v].p));
                chk("result_forfeit", 32'(result_forfeit), 0);
                @(posedge clk);
                @(negedge clk);
                btn = 4'b0000;
                chk("idle_busy", 32'(busy), 0);
                chk("idle_result_valid", 32'(result_valid), 0);
            end else begin
                chk("rearm_busy", 32'(busy), 1);
            end
            cif.core_win  = 1'b0;
            cif.core_lose = 1'b0;
            chk("wins", 32'(wins), 32'(tv[v].wins));
        end

        btn = 4'b0010;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midroll_rst_die1", 32'(die1), 1);
        chk("midroll_rst_die2", 32'(die2), 1);
        chk("midroll_rst_sum", 32'(cif.core_sum), 2);
        chk("midroll_rst_busy", 32'(busy), 0);
        chk("midroll_rst_owner", 32'(owner), 0);
        chk("midroll_rst_wins", 32'(wins), 0);
        chk("midroll_rst_result_valid", 32'(result_valid), 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        btn = 4'b0110;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_owner", 32'(owner), 1);
        chk("post_rst_core_rst", 32'(cif.core_rst), 1);
        @(posedge clk);
        @(negedge clk);
        btn = 4'b0000;
`ifdef DICE_TIMEOUT_EN
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (result_valid) break;
        end
        chk("timeout_cycles", 32'(cyc), 16);
        chk("timeout_valid", 32'(result_valid), 1);
        chk("timeout_win", 32'(result_win), 0);
        chk("timeout_forfeit", 32'(result_forfeit), 1);
        chk("timeout_player", 32'(result_player), 1);
`else
        seen_rv = 1'b0;
        seen_rb = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            seen_rv = seen_rv | result_valid;
            seen_rb = seen_rb | cif.core_rb;
        end
        chk("arm_wait_no_result", 32'(seen_rv), 0);
        chk("arm_wait_no_rb", 32'(seen_rb), 0);
        chk("arm_wait_busy", 32'(busy), 1);
        chk("arm_wait_owner", 32'(owner), 1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
